// File: rtl/vga_timing_pkg.sv
// Shared raster timing constants and helpers for the VGA timing generator
// and the downstream pixel generator.
package vga_timing_pkg;

    localparam int COORD_W   = 12;
    localparam int COORD_MAX = 1 << COORD_W;

    function automatic int axis_total(input int active, input int fp,
                                      input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    // 640x480 @ 60 Hz, 25.175 MHz pixel clock, both syncs active-low
    localparam int VGA640_H_ACTIVE = 640;
    localparam int VGA640_H_FP     = 16;
    localparam int VGA640_H_SYNC   = 96;
    localparam int VGA640_H_BP     = 48;
    localparam int VGA640_V_ACTIVE = 480;
    localparam int VGA640_V_FP     = 10;
    localparam int VGA640_V_SYNC   = 2;
    localparam int VGA640_V_BP     = 33;
    localparam bit VGA640_H_POL    = 1'b0;
    localparam bit VGA640_V_POL    = 1'b0;
    localparam int VGA640_H_TOTAL  = axis_total(VGA640_H_ACTIVE, VGA640_H_FP, VGA640_H_SYNC, VGA640_H_BP);
    localparam int VGA640_V_TOTAL  = axis_total(VGA640_V_ACTIVE, VGA640_V_FP, VGA640_V_SYNC, VGA640_V_BP);

    // 800x600 @ 60 Hz, 40 MHz pixel clock, both syncs active-high
    localparam int SVGA800_H_ACTIVE = 800;
    localparam int SVGA800_H_FP     = 40;
    localparam int SVGA800_H_SYNC   = 128;
    localparam int SVGA800_H_BP     = 88;
    localparam int SVGA800_V_ACTIVE = 600;
    localparam int SVGA800_V_FP     = 1;
    localparam int SVGA800_V_SYNC   = 4;
    localparam int SVGA800_V_BP     = 23;
    localparam bit SVGA800_H_POL    = 1'b1;
    localparam bit SVGA800_V_POL    = 1'b1;
    localparam int SVGA800_H_TOTAL  = axis_total(SVGA800_H_ACTIVE, SVGA800_H_FP, SVGA800_H_SYNC, SVGA800_H_BP);
    localparam int SVGA800_V_TOTAL  = axis_total(SVGA800_V_ACTIVE, SVGA800_V_FP, SVGA800_V_SYNC, SVGA800_V_BP);

endpackage

// File: rtl/vga_timing_gen_axis_counter.sv
// One raster axis: wrapping position counter plus unregistered active/sync
// decode of the current count.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE = 640,
    parameter int FP     = 16,
    parameter int SYNC   = 96,
    parameter int BP     = 48,
    parameter bit POL    = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    output logic [COORD_W-1:0] count,
    output logic               wrap,
    output logic               active,
    output logic               sync
);

    localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);

    localparam logic [COORD_W-1:0] LAST     = COORD_W'(TOTAL - 1);
    // One extra bit so a range ending exactly at COORD_MAX cannot alias to 0
    localparam logic [COORD_W:0]   ACT_END  = (COORD_W+1)'(ACTIVE);
    localparam logic [COORD_W:0]   SYNC_BEG = (COORD_W+1)'(ACTIVE + FP);
    localparam logic [COORD_W:0]   SYNC_END = (COORD_W+1)'(ACTIVE + FP + SYNC);

    logic [COORD_W:0] count_ext;
    logic             at_last;

    assign count_ext = {1'b0, count};
    assign at_last   = (count == LAST);
    assign wrap      = en && at_last;
    assign active    = (count_ext < ACT_END);
    assign sync      = ((count_ext >= SYNC_BEG) && (count_ext < SYNC_END)) ? POL : ~POL;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (en) begin
            count <= at_last ? '0 : count + COORD_W'(1);
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Free-running raster timing generator: registered position, visible-area,
// line/frame strobes and sync outputs with a programmable sync delay.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE   = VGA640_H_ACTIVE,
    parameter int H_FP       = VGA640_H_FP,
    parameter int H_SYNC     = VGA640_H_SYNC,
    parameter int H_BP       = VGA640_H_BP,
    parameter int V_ACTIVE   = VGA640_V_ACTIVE,
    parameter int V_FP       = VGA640_V_FP,
    parameter int V_SYNC     = VGA640_V_SYNC,
    parameter int V_BP       = VGA640_V_BP,
    parameter bit H_POL      = VGA640_H_POL,
    parameter bit V_POL      = VGA640_V_POL,
    parameter int SYNC_DELAY = 1
) (
    input  logic               pix_clk,
    input  logic               rst,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic               vid_active,
    output logic               hsync,
    output logic               vsync,
    output logic               line_start,
    output logic               frame_start
);

    localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    if (H_TOTAL > COORD_MAX || V_TOTAL > COORD_MAX) begin : g_total_chk
        $error("vga_timing_gen: H_TOTAL or V_TOTAL exceeds the coordinate range");
    end
    if (SYNC_DELAY < 0 || SYNC_DELAY > 4) begin : g_delay_chk
        $error("vga_timing_gen: SYNC_DELAY must be 0..4");
    end

    logic [COORD_W-1:0] h_cnt;
    logic [COORD_W-1:0] v_cnt;
    logic               h_wrap;
    logic               v_wrap_unused;
    logic               h_act;
    logic               v_act;
    logic               h_sync_dec;
    logic               v_sync_dec;

    // Stage 0 is aligned with pix_x; the pin taps the last stage
    logic [SYNC_DELAY:0] hs_pipe;
    logic [SYNC_DELAY:0] vs_pipe;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .POL    (H_POL)
    ) u_h_axis (
        .clk    (pix_clk),
        .rst    (rst),
        .en     (1'b1),
        .count  (h_cnt),
        .wrap   (h_wrap),
        .active (h_act),
        .sync   (h_sync_dec)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .POL    (V_POL)
    ) u_v_axis (
        .clk    (pix_clk),
        .rst    (rst),
        .en     (h_wrap),
        .count  (v_cnt),
        .wrap   (v_wrap_unused),
        .active (v_act),
        .sync   (v_sync_dec)
    );

    always_ff @(posedge pix_clk or posedge rst) begin
        if (rst) begin
            pix_x       <= '0;
            pix_y       <= '0;
            vid_active  <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            hs_pipe     <= {(SYNC_DELAY+1){~H_POL}};
            vs_pipe     <= {(SYNC_DELAY+1){~V_POL}};
        end else begin
            pix_x       <= h_cnt;
            pix_y       <= v_cnt;
            vid_active  <= h_act && v_act;
            line_start  <= (h_cnt == '0) && v_act;
            frame_start <= (h_cnt == '0) && (v_cnt == '0);
            hs_pipe[0]  <= h_sync_dec;
            vs_pipe[0]  <= v_sync_dec;
            for (int i = 1; i <= SYNC_DELAY; i++) begin
                hs_pipe[i] <= hs_pipe[i-1];
                vs_pipe[i] <= vs_pipe[i-1];
            end
        end
    end

    assign hsync = hs_pipe[SYNC_DELAY];
    assign vsync = vs_pipe[SYNC_DELAY];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default 640x480 timing plus two
// scaled-down configurations that make full-frame behaviour cheap to cover.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_d, rst_m, rst_s;
    logic [11:0] d_x, d_y, m_x, m_y, s_x, s_y;
    logic d_va, d_hs, d_vs, d_ls, d_fs;
    logic m_va, m_hs, m_vs, m_ls, m_fs;
    logic s_va, s_hs, s_vs, s_ls, s_fs;

    int total = 0;
    int bad   = 0;

    // Default 640x480@60, SYNC_DELAY = 1, active-low syncs
    vga_timing_gen dut_d (
        .pix_clk(clk), .rst(rst_d), .pix_x(d_x), .pix_y(d_y), .vid_active(d_va),
        .hsync(d_hs), .vsync(d_vs), .line_start(d_ls), .frame_start(d_fs)
    );

    // Medium: H 16/2/4/2 = 24, V 10/2/2/3 = 17, frame = 408 clocks
    vga_timing_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
        .V_ACTIVE(10), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .H_POL(1'b0), .V_POL(1'b0), .SYNC_DELAY(1)
    ) dut_m (
        .pix_clk(clk), .rst(rst_m), .pix_x(m_x), .pix_y(m_y), .vid_active(m_va),
        .hsync(m_hs), .vsync(m_vs), .line_start(m_ls), .frame_start(m_fs)
    );

    // Small: H 4/1/2/1 = 8, V 3/1/1/1 = 6, no delay, active-high syncs
    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .H_POL(1'b1), .V_POL(1'b1), .SYNC_DELAY(0)
    ) dut_s (
        .pix_clk(clk), .rst(rst_s), .pix_x(s_x), .pix_y(s_y), .vid_active(s_va),
        .hsync(s_hs), .vsync(s_vs), .line_start(s_ls), .frame_start(s_fs)
    );

    task automatic test_reset();
        rst_d = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (d_x !== 12'd0) begin bad++; $display("FAIL rst_pix_x got=%0d exp=0", d_x); end
        total++; if (d_va !== 1'b0) begin bad++; $display("FAIL rst_vid_active got=%b exp=0", d_va); end
        total++; if ({d_hs, d_vs} !== 2'b11) begin bad++; $display("FAIL rst_syncs got=%b exp=11", {d_hs, d_vs}); end
        total++; if ({d_ls, d_fs} !== 2'b00) begin bad++; $display("FAIL rst_strobes got=%b exp=00", {d_ls, d_fs}); end
        rst_d = 1'b0;
        @(negedge clk);
        total++; if ({d_x, d_y} !== 24'd0) begin bad++; $display("FAIL first_xy got=%0d,%0d exp=0,0", d_x, d_y); end
        total++; if ({d_va, d_ls, d_fs} !== 3'b111) begin bad++; $display("FAIL first_flags got=%b exp=111", {d_va, d_ls, d_fs}); end
        total++; if ({d_hs, d_vs} !== 2'b11) begin bad++; $display("FAIL first_syncs got=%b exp=11", {d_hs, d_vs}); end
    endtask

    // Starts on the first displayed cycle (0,0) and covers line 0 plus pixel 0 of line 1
    task automatic test_line();
        int hs_low = 0;
        int ls_cnt = 0;
        int xi, yi;
        logic [28:0] got_v, exp_v;
        for (int c = 0; c <= 800; c++) begin
            xi = c % 800;
            yi = c / 800;
            exp_v = {12'(xi), 12'(yi), (xi < 640), !(xi >= 657 && xi <= 752), 1'b1, (xi == 0), (c == 0)};
            got_v = {d_x, d_y, d_va, d_hs, d_vs, d_ls, d_fs};
            total++;
            if (got_v !== exp_v) begin
                bad++;
                $display("FAIL line c=%0d got=%h exp=%h", c, got_v, exp_v);
            end
            if (d_hs === 1'b0) hs_low++;
            if (d_ls === 1'b1) ls_cnt++;
            @(negedge clk);
        end
        total++; if (hs_low !== 96) begin bad++; $display("FAIL hsync_width got=%0d exp=96", hs_low); end
        total++; if (ls_cnt !== 2) begin bad++; $display("FAIL line_start_count got=%0d exp=2", ls_cnt); end
    endtask

    // Continues from cycle 801 of test_line (pixel 1 of line 1)
    task automatic test_mid_reset();
        repeat (699) @(negedge clk);
        total++; if ({d_x, d_y} !== {12'd700, 12'd1}) begin bad++; $display("FAIL pre_rst_xy got=%0d,%0d exp=700,1", d_x, d_y); end
        total++; if (d_hs !== 1'b0) begin bad++; $display("FAIL pre_rst_hsync got=%b exp=0", d_hs); end
        #2 rst_d = 1'b1;
        #1;
        total++; if ({d_x, d_y} !== 24'd0) begin bad++; $display("FAIL async_rst_xy got=%0d,%0d exp=0,0", d_x, d_y); end
        total++; if ({d_va, d_ls, d_fs} !== 3'b000) begin bad++; $display("FAIL async_rst_flags got=%b exp=000", {d_va, d_ls, d_fs}); end
        total++; if ({d_hs, d_vs} !== 2'b11) begin bad++; $display("FAIL async_rst_syncs got=%b exp=11", {d_hs, d_vs}); end
        @(negedge clk);
        rst_d = 1'b0;
        @(negedge clk);
        total++; if ({d_x, d_y, d_va, d_hs, d_ls, d_fs} !== {24'd0, 4'b1111}) begin
            bad++; $display("FAIL restart_first got x=%0d y=%0d flags=%b exp x=0 y=0 flags=1111", d_x, d_y, {d_va, d_hs, d_ls, d_fs});
        end
        @(negedge clk);
        total++; if ({d_x, d_fs, d_hs} !== {12'd1, 1'b0, 1'b1}) begin
            bad++; $display("FAIL restart_second got x=%0d fs=%b hs=%b exp x=1 fs=0 hs=1", d_x, d_fs, d_hs);
        end
    endtask

    // Medium config: one full frame plus the first cycle of the next
    task automatic test_frame();
        int ls_cnt = 0;
        int vs_low = 0;
        int fs_cnt = 0;
        int fs_last = -1;
        int fs_period = 0;
        int xi, yi;
        logic [28:0] got_v, exp_v;
        total++; if ({m_hs, m_vs, m_va} !== 3'b110) begin bad++; $display("FAIL m_rst got=%b exp=110", {m_hs, m_vs, m_va}); end
        rst_m = 1'b0;
        @(negedge clk);
        for (int c = 0; c <= 408; c++) begin
            xi = (c % 408) % 24;
            yi = (c % 408) / 24;
            exp_v = {12'(xi), 12'(yi), (xi < 16 && yi < 10), !(xi >= 19 && xi <= 22),
                     !((c % 408) >= 289 && (c % 408) < 337), (xi == 0 && yi < 10), (c % 408 == 0)};
            got_v = {m_x, m_y, m_va, m_hs, m_vs, m_ls, m_fs};
            total++;
            if (got_v !== exp_v) begin
                bad++;
                $display("FAIL frame c=%0d got=%h exp=%h", c, got_v, exp_v);
            end
            if (c < 408 && m_ls === 1'b1) ls_cnt++;
            if (c < 408 && m_vs === 1'b0) vs_low++;
            if (m_fs === 1'b1) begin
                fs_cnt++;
                if (fs_last >= 0) fs_period = c - fs_last;
                fs_last = c;
            end
            @(negedge clk);
        end
        total++; if (ls_cnt !== 10) begin bad++; $display("FAIL line_starts_per_frame got=%0d exp=10", ls_cnt); end
        total++; if (vs_low !== 48) begin bad++; $display("FAIL vsync_width got=%0d exp=48", vs_low); end
        total++; if (fs_cnt !== 2) begin bad++; $display("FAIL frame_start_count got=%0d exp=2", fs_cnt); end
        total++; if (fs_period !== 408) begin bad++; $display("FAIL frame_period got=%0d exp=408", fs_period); end
    endtask

    // Continues at cycle 409 and walks up to the second frame wrap
    task automatic test_wrap();
        for (int c = 409; c < 815; c++) begin
            if (c >= 745) begin
                total++;
                if (m_vs !== 1'b1) begin bad++; $display("FAIL vsync_glitch c=%0d got=%b exp=1", c, m_vs); end
            end
            @(negedge clk);
        end
        total++; if ({m_x, m_y} !== {12'd23, 12'd16}) begin bad++; $display("FAIL wrap_last_xy got=%0d,%0d exp=23,16", m_x, m_y); end
        total++; if ({m_va, m_vs, m_fs} !== 3'b010) begin bad++; $display("FAIL wrap_last_flags got=%b exp=010", {m_va, m_vs, m_fs}); end
        @(negedge clk);
        total++; if ({m_x, m_y} !== 24'd0) begin bad++; $display("FAIL wrap_first_xy got=%0d,%0d exp=0,0", m_x, m_y); end
        total++; if ({m_va, m_vs, m_ls, m_fs} !== 4'b1111) begin bad++; $display("FAIL wrap_first_flags got=%b exp=1111", {m_va, m_vs, m_ls, m_fs}); end
    endtask

    // Small config: active-high syncs with no extra delay
    task automatic test_small();
        int fs_cnt = 0;
        int hs_cnt = 0;
        int xi, yi;
        logic [28:0] got_v, exp_v;
        total++; if ({s_hs, s_vs} !== 2'b00) begin bad++; $display("FAIL s_rst_syncs got=%b exp=00", {s_hs, s_vs}); end
        rst_s = 1'b0;
        @(negedge clk);
        for (int c = 0; c <= 48; c++) begin
            xi = c % 8;
            yi = (c / 8) % 6;
            exp_v = {12'(xi), 12'(yi), (xi < 4 && yi < 3), (xi == 5 || xi == 6), (yi == 4),
                     (xi == 0 && yi < 3), (c % 48 == 0)};
            got_v = {s_x, s_y, s_va, s_hs, s_vs, s_ls, s_fs};
            total++;
            if (got_v !== exp_v) begin
                bad++;
                $display("FAIL small c=%0d got=%h exp=%h", c, got_v, exp_v);
            end
            if (s_fs === 1'b1) fs_cnt++;
            if (c < 48 && s_hs === 1'b1) hs_cnt++;
            @(negedge clk);
        end
        total++; if (fs_cnt !== 2) begin bad++; $display("FAIL small_frame_starts got=%0d exp=2", fs_cnt); end
        total++; if (hs_cnt !== 12) begin bad++; $display("FAIL small_hsync_count got=%0d exp=12", hs_cnt); end
    endtask

    initial begin
        rst_d = 1'b1;
        rst_m = 1'b1;
        rst_s = 1'b1;
        @(negedge clk);
        test_reset();
        test_line();
        test_mid_reset();
        test_frame();
        test_wrap();
        test_small();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
